// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline control blocks: register address width,
// forward-select encodings, hazard FSM states and the register-match helper.
package core_pkg;

  localparam int unsigned REG_AW = 4;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [0:0] {
    StRun,
    StMulti
  } hz_state_e;

  // Register 0 is hardwired when zero_reg is set, so it can never carry a dependency.
  function automatic logic addr_match(logic [REG_AW-1:0] a, logic [REG_AW-1:0] b,
                                      logic zero_reg);
    return (a == b) && !(zero_reg && (a == '0));
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Combinational operand-forwarding select for one EX source register.
module fwd_unit
  import core_pkg::*;
#(
  parameter bit ZERO_REG = 1'b1
) (
  input  logic [REG_AW-1:0] src_addr,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic              mem_wr_en,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic              wb_wr_en,
  output logic [1:0]        fwd_sel
);

  // MEM holds the younger result, so it wins over WB.
  always_comb begin
    fwd_sel = FWD_RF;
    if (mem_wr_en && addr_match(mem_rd_addr, src_addr, ZERO_REG)) begin
      fwd_sel = FWD_MEM;
    end else if (wb_wr_en && addr_match(wb_rd_addr, src_addr, ZERO_REG)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/bubble/flush decode, EX operand forwarding,
// multi-cycle ALU sequencing and saturating debug event counters.
module pipe_hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned MULTI_LAT = 4,
  parameter bit          ZERO_REG  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rq_addr,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic              id_uses_rq,
  input  logic              id_uses_rs,
  input  logic [REG_AW-1:0] ex_rq_addr,
  input  logic [REG_AW-1:0] ex_rs_addr,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic              ex_wr_en,
  input  logic              ex_is_load,
  input  logic              ex_multi,
  input  logic              ex_flush,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic              mem_wr_en,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic              wb_wr_en,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              idex_hold,
  output logic              idex_bubble,
  output logic              exmem_bubble,
  output logic              ifid_flush,
  output logic [1:0]        fwd_rq_sel,
  output logic [1:0]        fwd_rs_sel,
  output logic              alu_busy,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
);

  localparam logic [3:0]  CntInit = 4'(MULTI_LAT - 2);
  localparam logic [15:0] CntMax  = 16'hFFFF;

  hz_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_cnt_q, flush_cnt_q;
  logic        load_use;
  logic        hold_c, idex_hold_c, idex_bubble_c, exmem_bubble_c, ifid_flush_c, busy_c;
  logic [1:0]  fwd_rq_raw, fwd_rs_raw;

  assign load_use = ex_is_load && ex_wr_en &&
                    ((id_uses_rq && addr_match(ex_rd_addr, id_rq_addr, ZERO_REG)) ||
                     (id_uses_rs && addr_match(ex_rd_addr, id_rs_addr, ZERO_REG)));

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    hold_c         = 1'b0;
    idex_hold_c    = 1'b0;
    idex_bubble_c  = 1'b0;
    exmem_bubble_c = 1'b0;
    ifid_flush_c   = 1'b0;
    busy_c         = 1'b0;
    case (state_q)
      StRun: begin
        if (ex_flush) begin
          ifid_flush_c  = 1'b1;
          idex_bubble_c = 1'b1;
        end else if (ex_multi) begin
          hold_c         = 1'b1;
          idex_hold_c    = 1'b1;
          exmem_bubble_c = 1'b1;
          cnt_d          = CntInit;
          // A 2-cycle op needs only this one held cycle, so MULTI is skipped.
          if (MULTI_LAT > 2) state_d = StMulti;
        end else if (load_use) begin
          hold_c        = 1'b1;
          idex_bubble_c = 1'b1;
        end
      end
      StMulti: begin
        hold_c         = 1'b1;
        idex_hold_c    = 1'b1;
        exmem_bubble_c = 1'b1;
        busy_c         = 1'b1;
        cnt_d          = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  fwd_unit #(.ZERO_REG(ZERO_REG)) u_fwd_rq (
    .src_addr    (ex_rq_addr),
    .mem_rd_addr (mem_rd_addr),
    .mem_wr_en   (mem_wr_en),
    .wb_rd_addr  (wb_rd_addr),
    .wb_wr_en    (wb_wr_en),
    .fwd_sel     (fwd_rq_raw)
  );

  fwd_unit #(.ZERO_REG(ZERO_REG)) u_fwd_rs (
    .src_addr    (ex_rs_addr),
    .mem_rd_addr (mem_rd_addr),
    .mem_wr_en   (mem_wr_en),
    .wb_rd_addr  (wb_rd_addr),
    .wb_wr_en    (wb_wr_en),
    .fwd_sel     (fwd_rs_raw)
  );

  // Controls are forced quiet for the whole time reset is low, not just at the edge.
  assign pc_hold      = rst_n & hold_c;
  assign ifid_hold    = rst_n & hold_c;
  assign idex_hold    = rst_n & idex_hold_c;
  assign idex_bubble  = rst_n & idex_bubble_c;
  assign exmem_bubble = rst_n & exmem_bubble_c;
  assign ifid_flush   = rst_n & ifid_flush_c;
  assign alu_busy     = rst_n & busy_c;
  assign fwd_rq_sel   = rst_n ? fwd_rq_raw : FWD_RF;
  assign fwd_rs_sel   = rst_n ? fwd_rs_raw : FWD_RF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_hold && (stall_cnt_q != CntMax)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (ifid_flush && (flush_cnt_q != CntMax)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: per-cycle comparison against a
// remaining-cycles model plus hand-computed pinned expectations.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MULTI_LAT = 4;
  localparam bit          ZERO_REG  = 1'b1;

  // Control vector order: pc_hold, ifid_hold, idex_hold, idex_bubble, exmem_bubble,
  // ifid_flush, alu_busy
  localparam logic [6:0] CtlNone   = 7'b0000000;
  localparam logic [6:0] CtlLoad   = 7'b1101000;
  localparam logic [6:0] CtlMStart = 7'b1110100;
  localparam logic [6:0] CtlMBusy  = 7'b1110101;
  localparam logic [6:0] CtlFlush  = 7'b0001010;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] id_rq_addr, id_rs_addr, ex_rq_addr, ex_rs_addr, ex_rd_addr;
  logic       id_uses_rq, id_uses_rs, ex_wr_en, ex_is_load, ex_multi, ex_flush;
  logic [3:0] mem_rd_addr, wb_rd_addr;
  logic       mem_wr_en, wb_wr_en;
  logic       pc_hold, ifid_hold, idex_hold, idex_bubble, exmem_bubble, ifid_flush, alu_busy;
  logic [1:0] fwd_rq_sel, fwd_rs_sel;
  logic [15:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: MULTI cycles still owed after the entry cycle, and event totals.
  int m_left;
  int m_stall;
  int m_flush;

  // Pinned literal expectations, set by the stimulus and checked by the compare process.
  logic        pin_ctl_en = 1'b0;
  logic [6:0]  pin_ctl;
  logic        pin_cnt_en = 1'b0;
  int          pin_stall, pin_flush;
  logic        pin_fwd_en = 1'b0;
  logic [1:0]  pin_rq, pin_rs;

  pipe_hazard_ctrl #(.MULTI_LAT(MULTI_LAT), .ZERO_REG(ZERO_REG)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rq_addr   (id_rq_addr),
    .id_rs_addr   (id_rs_addr),
    .id_uses_rq   (id_uses_rq),
    .id_uses_rs   (id_uses_rs),
    .ex_rq_addr   (ex_rq_addr),
    .ex_rs_addr   (ex_rs_addr),
    .ex_rd_addr   (ex_rd_addr),
    .ex_wr_en     (ex_wr_en),
    .ex_is_load   (ex_is_load),
    .ex_multi     (ex_multi),
    .ex_flush     (ex_flush),
    .mem_rd_addr  (mem_rd_addr),
    .mem_wr_en    (mem_wr_en),
    .wb_rd_addr   (wb_rd_addr),
    .wb_wr_en     (wb_wr_en),
    .pc_hold      (pc_hold),
    .ifid_hold    (ifid_hold),
    .idex_hold    (idex_hold),
    .idex_bubble  (idex_bubble),
    .exmem_bubble (exmem_bubble),
    .ifid_flush   (ifid_flush),
    .fwd_rq_sel   (fwd_rq_sel),
    .fwd_rs_sel   (fwd_rs_sel),
    .alu_busy     (alu_busy),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic live(logic [3:0] a, logic [3:0] b);
    return (a == b) && (!ZERO_REG || a != 4'd0);
  endfunction

  function automatic logic [6:0] exp_ctl();
    logic lu;
    if (!rst_n) return CtlNone;
    if (m_left > 0) return CtlMBusy;
    if (ex_flush) return CtlFlush;
    if (ex_multi) return CtlMStart;
    lu = ex_is_load && ex_wr_en &&
         ((id_uses_rq && live(ex_rd_addr, id_rq_addr)) ||
          (id_uses_rs && live(ex_rd_addr, id_rs_addr)));
    return lu ? CtlLoad : CtlNone;
  endfunction

  function automatic logic [1:0] exp_fwd(logic [3:0] src);
    if (!rst_n) return 2'b00;
    if (mem_wr_en && live(mem_rd_addr, src)) return 2'b01;
    if (wb_wr_en && live(wb_rd_addr, src)) return 2'b10;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left  <= 0;
      m_stall <= 0;
      m_flush <= 0;
    end else begin
      if (exp_ctl() & CtlLoad & CtlMStart & 7'b1000000) begin
        if (m_stall < 65535) m_stall <= m_stall + 1;
      end
      if (exp_ctl() & 7'b0000010) begin
        if (m_flush < 65535) m_flush <= m_flush + 1;
      end
      if (m_left > 0) m_left <= m_left - 1;
      else if (!ex_flush && ex_multi) m_left <= MULTI_LAT - 2;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [6:0] ctl;
    ctl = {pc_hold, ifid_hold, idex_hold, idex_bubble, exmem_bubble, ifid_flush, alu_busy};
    chk("ctl", 32'(ctl), 32'(exp_ctl()));
    chk("fwd_rq", 32'(fwd_rq_sel), 32'(exp_fwd(ex_rq_addr)));
    chk("fwd_rs", 32'(fwd_rs_sel), 32'(exp_fwd(ex_rs_addr)));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    if (pin_ctl_en) chk("pin_ctl", 32'(ctl), 32'(pin_ctl));
    if (pin_cnt_en) begin
      chk("pin_stall", 32'(stall_cnt), 32'(pin_stall));
      chk("pin_flush", 32'(flush_cnt), 32'(pin_flush));
    end
    if (pin_fwd_en) begin
      chk("pin_fwd_rq", 32'(fwd_rq_sel), 32'(pin_rq));
      chk("pin_fwd_rs", 32'(fwd_rs_sel), 32'(pin_rs));
    end
  end

  task automatic clr();
    id_rq_addr = 0; id_rs_addr = 0; id_uses_rq = 0; id_uses_rs = 0;
    ex_rq_addr = 0; ex_rs_addr = 0; ex_rd_addr = 0;
    ex_wr_en = 0; ex_is_load = 0; ex_multi = 0; ex_flush = 0;
    mem_rd_addr = 0; mem_wr_en = 0; wb_rd_addr = 0; wb_wr_en = 0;
  endtask

  task automatic set_load_use(input logic [3:0] rd, input logic [3:0] rq);
    ex_is_load = 1; ex_wr_en = 1; ex_rd_addr = rd; id_rq_addr = rq; id_uses_rq = 1;
  endtask

  task automatic pctl(input logic [6:0] v);
    pin_ctl_en = 1; pin_ctl = v;
  endtask

  task automatic pcnt(input int s, input int f);
    pin_cnt_en = 1; pin_stall = s; pin_flush = f;
  endtask

  task automatic pfwd(input logic [1:0] rq, input logic [1:0] rs);
    pin_fwd_en = 1; pin_rq = rq; pin_rs = rs;
  endtask

  // Let the negedge compare run, drop the pins, then move to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    #1;
    pin_ctl_en = 0; pin_cnt_en = 0; pin_fwd_en = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0;
    clr();
    // Hazard-looking inputs while in reset must not leak through.
    set_load_use(4'd5, 4'd5);
    ex_rs_addr = 7; mem_rd_addr = 7; mem_wr_en = 1;
    pctl(CtlNone); pcnt(0, 0); pfwd(2'b00, 2'b00);
    tick();
    rst_n = 1;
    clr();
    tick();

    // Load-use through rq: one bubble.
    set_load_use(4'd5, 4'd5);
    pctl(CtlLoad);
    tick();
    clr();
    pctl(CtlNone); pcnt(1, 0);
    tick();
    // Register 0 never forms a dependency; rs match is ignored when rs unused.
    set_load_use(4'd0, 4'd0);
    pctl(CtlNone);
    tick();
    clr();
    ex_is_load = 1; ex_wr_en = 1; ex_rd_addr = 9; id_rs_addr = 9; id_uses_rs = 0;
    pctl(CtlNone);
    tick();
    id_uses_rs = 1;
    pctl(CtlLoad);
    tick();
    clr();
    pcnt(2, 0);
    tick();

    // Multi-cycle op pulsed: 3 held cycles, busy for the last 2.
    ex_multi = 1;
    pctl(CtlMStart);
    tick();
    clr();
    set_load_use(4'd3, 4'd3);
    ex_flush = 1;
    pctl(CtlMBusy);
    tick();
    clr();
    pctl(CtlMBusy);
    tick();
    pctl(CtlNone); pcnt(5, 0);
    tick();

    // Flush wins over load-use and multi.
    set_load_use(4'd5, 4'd5);
    ex_flush = 1; ex_multi = 1;
    pctl(CtlFlush);
    tick();
    clr();
    pctl(CtlNone); pcnt(5, 1);
    tick();

    // Forwarding priority.
    ex_rs_addr = 7; ex_rq_addr = 7; mem_rd_addr = 7; wb_rd_addr = 7;
    mem_wr_en = 1; wb_wr_en = 1;
    pfwd(2'b01, 2'b01);
    tick();
    mem_wr_en = 0; ex_rq_addr = 4;
    pfwd(2'b00, 2'b10);
    tick();
    mem_wr_en = 1; mem_rd_addr = 4;
    pfwd(2'b01, 2'b10);
    tick();
    ex_rs_addr = 0; ex_rq_addr = 0; mem_rd_addr = 0; wb_rd_addr = 0;
    pfwd(2'b00, 2'b00);
    tick();
    clr();

    // Asynchronous reset in the middle of MULTI.
    ex_multi = 1;
    tick();
    clr();
    #2;
    rst_n = 0;
    pctl(CtlNone); pcnt(0, 0);
    tick();
    rst_n = 1;
    pctl(CtlNone); pcnt(0, 0);
    tick();
    pctl(CtlNone); pcnt(0, 0);
    tick();

    // Saturation of the stall counter.
    set_load_use(4'd6, 4'd6);
    repeat (65540) @(posedge clk);
    #1;
    pctl(CtlLoad); pcnt(65535, 0);
    tick();
    clr();
    pctl(CtlNone); pcnt(65535, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard controller for the 5-stage 16-bit-instruction core. It sequences the execute stage and its ALU:
- generates stall/hold, bubble and flush controls for the IF/ID, ID/EX and EX/MEM boundaries;
- selects operand forwarding for the execute stage;
- runs a counter FSM that holds the pipeline while a multi-cycle ALU operation occupies EX.

It also keeps saturating stall and flush event counters for debug.

## Interface
Parameters:
- MULTI_LAT, 4: total EX-occupancy cycles of a multi-cycle ALU op (legal 2..15).
- ZERO_REG, 1: if 1, register 0 never matches for hazards or forwarding.

Ports:
- clk  in  1  single core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rq_addr, id_rs_addr  in  4 each  source registers of the instruction in ID.
- id_uses_rq, id_uses_rs  in  1 each  ID instruction reads that source.
- ex_rq_addr, ex_rs_addr  in  4 each  source registers of the instruction in EX.
- ex_rd_addr  in  4  EX destination; ex_wr_en  in  1; ex_is_load  in  1.
- ex_multi  in  1  EX holds a multi-cycle ALU op.
- ex_flush  in  1  EX resolved a taken branch or jump.
- mem_rd_addr  in  4; mem_wr_en  in  1  MEM-stage destination.
- wb_rd_addr  in  4; wb_wr_en  in  1  WB-stage destination.
- pc_hold, ifid_hold  out  1 each  freeze PC and IF/ID.
- idex_hold  out  1  freeze ID/EX.
- idex_bubble  out  1  load NOP into ID/EX.
- exmem_bubble  out  1  load NOP into EX/MEM.
- ifid_flush  out  1  load NOP into IF/ID.
- fwd_rq_sel, fwd_rs_sel  out  2 each  00 register file, 01 MEM result, 10 WB result.
- alu_busy  out  1  high in MULTI state.
- stall_cnt, flush_cnt  out  16 each  saturating event counters.

## Operation
- FSM states: RUN and MULTI. A 4-bit down-counter `cnt` runs alongside.
- **RUN, ex_flush=1** (highest priority):
  - ifid_flush=1 and idex_bubble=1; no holds.
  - flush_cnt increments.
  - ex_multi in the same cycle is ignored (illegal combination, defined outcome).
- **RUN, ex_multi=1**:
  - pc_hold, ifid_hold, idex_hold and exmem_bubble all =1.
  - cnt <= MULTI_LAT-2; next state MULTI.
- **RUN, load-use**:
  - Condition: ex_is_load & ex_wr_en, and ex_rd_addr equals a used ID source.
  - pc_hold=1, ifid_hold=1, idex_bubble=1 for exactly one cycle.
- **MULTI**:
  - Same holds and bubble as ex_multi in RUN; alu_busy=1; ex_flush and load-use are ignored.
  - cnt decrements each cycle.
  - When cnt==1, next state is RUN; the following cycle releases the holds.
- stall_cnt increments in every cycle where pc_hold=1. Both counters saturate at 16'hFFFF.
- **Forwarding** (combinational, every state), per EX source:
  - mem_wr_en match → 01;
  - else wb_wr_en match → 10;
  - else 00.
  - MEM beats WB.
- ZERO_REG=1: any address equal to 0 never produces a match, for either forwarding or load-use detection.

## Timing
- Reset: state RUN, cnt 0, both counters 0.
- While rst_n=0, all hold, bubble and flush outputs, alu_busy and fwd selects are forced 0.
- Reset deassertion mid-MULTI: the FSM restarts in RUN; no residual holds.
- Hold, bubble and flush outputs are combinational from inputs and state, valid in the same cycle; pipeline registers act on the next edge.
- A multi-cycle op holds the pipeline for MULTI_LAT-1 cycles and occupies EX for MULTI_LAT cycles.
- Load-use costs exactly one bubble.
- Flush costs two squashed instructions: IF/ID and ID/EX.
- Counters update on the edge following the event cycle.

## Structure
- Shared package `core_pkg`:
  - register-address width (4);
  - forward-select encodings FWD_RF, FWD_MEM, FWD_WB;
  - FSM state enum.
- Optional sub-module `fwd_unit`: purely combinational forwarding comparators, instantiated once per EX source.
- FSM, counter, hold/bubble decode and event counters stay in the top module.

## Test plan
- **Load-use**: ex_is_load=1, ex_wr_en=1, ex_rd_addr=5, id_rq_addr=5, id_uses_rq=1 → one cycle of pc_hold, ifid_hold and idex_bubble; stall_cnt=1.
- **Multi-cycle op**: MULTI_LAT=4, ex_multi pulsed into RUN → holds for exactly 3 cycles; alu_busy high for 2; RUN on cycle 4; stall_cnt=3.
- **Branch flush**: ex_flush=1 together with a load-use match → only ifid_flush and idex_bubble assert; no holds; flush_cnt=1.
- **Forwarding priority**: mem_rd_addr=wb_rd_addr=ex_rs_addr=7, both write enables high → fwd_rs_sel=01. With ex_rs_addr=0 → 00.
- **Async reset mid-MULTI**: assert rst_n=0 → all outputs 0 immediately; after release, state RUN and counters 0.
- **Saturation**: preload via 65,540 stall cycles → stall_cnt holds at 16'hFFFF.
